// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and data memory.
// slave = the load/store unit's view; master = the surrounding pipeline/memory.
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_load;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [4:0]      req_rd;

   logic            mem_valid;
   logic            mem_ready;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [3:0]      mem_be;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   logic            ld_valid;
   logic [XLEN-1:0] ld_data;
   logic [4:0]      ld_rd;
   logic            stall;
   logic            misalign;

   modport slave (
      input  req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      input  mem_ready, mem_rdata,
      output req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
      output ld_valid, ld_data, ld_rd, stall, misalign
   );

   modport master (
      output req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      output mem_ready, mem_rdata,
      input  req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
      input  ld_valid, ld_data, ld_rd, stall, misalign
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one load/store per transaction on a valid/ready data bus.
// Optional MISALIGN_TRAP_EN: misaligned requests skip the bus and pulse misalign instead.
module load_store_unit #(
   parameter int XLEN = 32
) (
   input logic               clk,
   input logic               rst,
   load_store_unit_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
`ifdef MISALIGN_TRAP_EN
   localparam logic [1:0] S_ERR  = 2'd3;
`endif

   logic [1:0]      r_state;
   logic [1:0]      r_lane;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic            r_load;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_mem_addr;
   logic [3:0]      r_mem_be;
   logic [XLEN-1:0] r_mem_wdata;
   logic [XLEN-1:0] r_ld_data;
   logic [4:0]      r_ld_rd;

   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_ld_data;
   logic            w_sext;

`ifdef MISALIGN_TRAP_EN
   logic w_misaligned;
   assign w_misaligned = (bus.req_size == 2'b01) ? bus.req_addr[0]
                       : (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`endif

   // Request-side lane steering, computed from the live request and captured on accept.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_be    = 4'b1111;
      w_wdata = bus.req_wdata;
      case (bus.req_size)
         2'b00: begin
            w_be    = 4'b0001 << bus.req_addr[1:0];
            w_wdata = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << {bus.req_addr[1], 1'b0};
            w_wdata = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load-side lane extraction; word (and reserved size 11) passes the read word through.
   always_comb begin
      w_byte    = bus.mem_rdata[{r_lane, 3'b000} +: 8];
      w_half    = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      w_sext    = 1'b0;
      w_ld_data = bus.mem_rdata;
      case (r_size)
         2'b00: begin
            w_sext    = ~r_unsigned & w_byte[7];
            w_ld_data = {{24{w_sext}}, w_byte};
         end
         2'b01: begin
            w_sext    = ~r_unsigned & w_half[15];
            w_ld_data = {{16{w_sext}}, w_half};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (rst) begin
         r_state     <= S_IDLE;
         r_lane      <= '0;
         r_size      <= '0;
         r_unsigned  <= 1'b0;
         r_load      <= 1'b0;
         r_rd        <= '0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_ld_data   <= '0;
         r_ld_rd     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_lane      <= bus.req_addr[1:0];
                  r_size      <= bus.req_size;
                  r_unsigned  <= bus.req_unsigned;
                  r_load      <= bus.req_load;
                  r_rd        <= bus.req_rd;
                  r_mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
`ifdef MISALIGN_TRAP_EN
                  r_state     <= w_misaligned ? S_ERR : S_BUS;
`else
                  r_state     <= S_BUS;
`endif
               end
            end
            S_BUS: begin
               if (bus.mem_ready) begin
                  if (r_load) begin
                     r_ld_data <= w_ld_data;
                     r_ld_rd   <= r_rd;
                     r_state   <= S_RESP;
                  end else begin
                     r_state   <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.stall     = (r_state != S_IDLE);
   assign bus.mem_valid = (r_state == S_BUS);
   assign bus.mem_we    = (r_state == S_BUS) & ~r_load;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_be    = r_mem_be;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.ld_valid  = (r_state == S_RESP);
   assign bus.ld_data   = r_ld_data;
   assign bus.ld_rd     = r_ld_rd;
`ifdef MISALIGN_TRAP_EN
   assign bus.misalign  = (r_state == S_ERR);
`else
   assign bus.misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner cases,
// and random transactions checked against a byte-lane arithmetic reference model.
module tb_load_store_unit;

   typedef struct {
      logic        load;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_ld;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks   = 0;
   int   n_failures = 0;
   logic [31:0] last_ld = '0;
   logic [4:0]  last_rd = '0;

   load_store_unit_if bus ();

   load_store_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] rdat, input int dly, input logic [31:0] ea,
                               input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
      vec_t v;
      v.load = ld;  v.size = sz;  v.uns = un;  v.addr = a;  v.wdata = wd;  v.rd = rd;
      v.rdata = rdat;  v.delay = dly;  v.e_addr = ea;  v.e_be = ebe;  v.e_wdata = ewd;  v.e_ld = eld;
      return v;
   endfunction

   function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
      int off = int'(a % 4);
      if (sz == 2'd1) return (off % 2) != 0;
      if (sz >= 2'd2) return off != 0;
      return 1'b0;
   endfunction

   // Reference model: lane offsets, masks and sign extension by plain arithmetic.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int   off = int'(v.addr % 4);
      longint unsigned val;
      r.e_addr = v.addr - 32'(off);
      if (v.size == 2'd0) begin
         r.e_be    = 4'(1 << off);
         r.e_wdata = (v.wdata % 256) * 32'h0101_0101;
         val       = (longint'(v.rdata) >> (8 * off)) % 256;
         if (!v.uns && val >= 128) val = val + 64'hFFFF_FF00;
         r.e_ld    = 32'(val);
      end else if (v.size == 2'd1) begin
         r.e_be    = (off >= 2) ? 4'd12 : 4'd3;
         r.e_wdata = (v.wdata % 65536) * 32'h0001_0001;
         val       = (longint'(v.rdata) >> ((off >= 2) ? 16 : 0)) % 65536;
         if (!v.uns && val >= 32768) val = val + 64'hFFFF_0000;
         r.e_ld    = 32'(val);
      end else begin
         r.e_be    = 4'd15;
         r.e_wdata = v.wdata;
         r.e_ld    = v.rdata;
      end
      return r;
   endfunction

   // Runs one transaction from IDLE back to IDLE, checking every cycle along the way.
   task automatic run_txn(input vec_t v, input string tag);
      check({tag, " req_ready idle"}, 32'(bus.req_ready), 1);
      bus.req_valid    = 1'b1;
      bus.req_load     = v.load;
      bus.req_size     = v.size;
      bus.req_unsigned = v.uns;
      bus.req_addr     = v.addr;
      bus.req_wdata    = v.wdata;
      bus.req_rd       = v.rd;
      @(posedge clk); #1;
      bus.req_valid    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (is_mis(v.size, v.addr)) begin
         check({tag, " misalign pulse"}, 32'(bus.misalign), 1);
         check({tag, " err mem_valid"}, 32'(bus.mem_valid), 0);
         check({tag, " err ld_valid"}, 32'(bus.ld_valid), 0);
         check({tag, " err stall"}, 32'(bus.stall), 1);
         @(posedge clk); #1;
         check({tag, " misalign drop"}, 32'(bus.misalign), 0);
         check({tag, " err end mem_valid"}, 32'(bus.mem_valid), 0);
         check({tag, " err end stall"}, 32'(bus.stall), 0);
         check({tag, " err ld_data hold"}, bus.ld_data, last_ld);
         return;
      end
`endif
      for (int i = 0; i <= v.delay; i++) begin
         check({tag, " mem_valid"}, 32'(bus.mem_valid), 1);
         check({tag, " mem_addr"}, bus.mem_addr, v.e_addr);
         check({tag, " mem_be"}, 32'(bus.mem_be), 32'(v.e_be));
         check({tag, " mem_we"}, 32'(bus.mem_we), 32'(!v.load));
         if (!v.load) check({tag, " mem_wdata"}, bus.mem_wdata, v.e_wdata);
         check({tag, " stall"}, 32'(bus.stall), 1);
         check({tag, " req_ready busy"}, 32'(bus.req_ready), 0);
         check({tag, " ld_valid early"}, 32'(bus.ld_valid), 0);
         check({tag, " misalign quiet"}, 32'(bus.misalign), 0);
         // A competing request while busy must be ignored.
         bus.req_valid = 1'b1;
         bus.req_load  = 1'($urandom_range(0, 1));
         bus.req_addr  = $urandom;
         bus.mem_ready = (i == v.delay);
         bus.mem_rdata = (i == v.delay) ? v.rdata : $urandom;
         @(posedge clk); #1;
         bus.mem_ready = 1'b0;
         bus.req_valid = 1'b0;
      end
      if (v.load) begin
         check({tag, " ld_valid"}, 32'(bus.ld_valid), 1);
         check({tag, " ld_data"}, bus.ld_data, v.e_ld);
         check({tag, " ld_rd"}, 32'(bus.ld_rd), 32'(v.rd));
         check({tag, " resp mem_valid"}, 32'(bus.mem_valid), 0);
         last_ld = v.e_ld;
         last_rd = v.rd;
         bus.mem_ready = 1'b1;
         @(posedge clk); #1;
         bus.mem_ready = 1'b0;
      end
      check({tag, " ld_valid done"}, 32'(bus.ld_valid), 0);
      check({tag, " req_ready done"}, 32'(bus.req_ready), 1);
      check({tag, " stall done"}, 32'(bus.stall), 0);
      check({tag, " mem_valid done"}, 32'(bus.mem_valid), 0);
      check({tag, " ld_data hold"}, bus.ld_data, last_ld);
      check({tag, " ld_rd hold"}, 32'(bus.ld_rd), 32'(last_rd));
   endtask

   vec_t tbl[12];
   vec_t rv;

   initial begin
      bus.req_valid = 1'b0;  bus.req_load = 1'b0;  bus.req_size = '0;  bus.req_unsigned = 1'b0;
      bus.req_addr = '0;  bus.req_wdata = '0;  bus.req_rd = '0;
      bus.mem_ready = 1'b0;  bus.mem_rdata = '0;

      //        ld sz  un addr          wdata         rd    rdata         dly e_addr        be     e_wdata       e_ld
      tbl[0]  = mk(1, 2, 0, 32'h100, 32'h0,         5'd5,  32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,         32'hDEADBEEF);
      tbl[1]  = mk(1, 0, 0, 32'h103, 32'h0,         5'd6,  32'h80112233, 0, 32'h100, 4'b1000, 32'h0,         32'hFFFFFF80);
      tbl[2]  = mk(1, 0, 1, 32'h103, 32'h0,         5'd7,  32'h80112233, 1, 32'h100, 4'b1000, 32'h0,         32'h00000080);
      tbl[3]  = mk(0, 1, 0, 32'h202, 32'h0000ABCD,  5'd0,  32'h0,        0, 32'h200, 4'b1100, 32'hABCDABCD,  32'h0);
      tbl[4]  = mk(1, 2, 0, 32'h100, 32'h0,         5'd9,  32'h12345678, 3, 32'h100, 4'b1111, 32'h0,         32'h12345678);
      tbl[5]  = mk(1, 1, 0, 32'h002, 32'h0,         5'd10, 32'h80017FFF, 0, 32'h000, 4'b1100, 32'h0,         32'hFFFF8001);
      tbl[6]  = mk(1, 1, 1, 32'h000, 32'h0,         5'd11, 32'h80017FFF, 2, 32'h000, 4'b0011, 32'h0,         32'h00007FFF);
      tbl[7]  = mk(0, 0, 0, 32'h301, 32'h123456A5,  5'd0,  32'h0,        1, 32'h300, 4'b0010, 32'hA5A5A5A5,  32'h0);
      tbl[8]  = mk(1, 0, 0, 32'h001, 32'h0,         5'd12, 32'h00007F00, 0, 32'h000, 4'b0010, 32'h0,         32'h0000007F);
      tbl[9]  = mk(1, 3, 1, 32'h010, 32'h0,         5'd13, 32'h55AA55AA, 0, 32'h010, 4'b1111, 32'h0,         32'h55AA55AA);
      tbl[10] = mk(1, 2, 0, 32'h102, 32'h0,         5'd14, 32'h0BADF00D, 0, 32'h100, 4'b1111, 32'h0,         32'h0BADF00D);
      tbl[11] = mk(1, 1, 0, 32'h003, 32'h0,         5'd15, 32'h9ABC1234, 0, 32'h000, 4'b1100, 32'h0,         32'hFFFF9ABC);

      // Reset state.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset req_ready", 32'(bus.req_ready), 1);
      check("reset mem_valid", 32'(bus.mem_valid), 0);
      check("reset mem_we", 32'(bus.mem_we), 0);
      check("reset ld_valid", 32'(bus.ld_valid), 0);
      check("reset misalign", 32'(bus.misalign), 0);
      check("reset stall", 32'(bus.stall), 0);
      check("reset mem_addr", bus.mem_addr, 0);
      check("reset mem_be", 32'(bus.mem_be), 0);
      check("reset mem_wdata", bus.mem_wdata, 0);
      check("reset ld_data", bus.ld_data, 0);
      check("reset ld_rd", 32'(bus.ld_rd), 0);

      for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Reset asserted in the second BUS cycle abandons the load.
      bus.req_valid = 1'b1;  bus.req_load = 1'b1;  bus.req_size = 2'd2;
      bus.req_addr = 32'h500;  bus.req_rd = 5'd7;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("midrst bus1 mem_valid", 32'(bus.mem_valid), 1);
      @(posedge clk); #1;
      check("midrst bus2 mem_valid", 32'(bus.mem_valid), 1);
      check("midrst bus2 mem_addr", bus.mem_addr, 32'h500);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst mem_valid", 32'(bus.mem_valid), 0);
      check("midrst stall", 32'(bus.stall), 0);
      check("midrst req_ready", 32'(bus.req_ready), 1);
      check("midrst ld_data", bus.ld_data, 0);
      last_ld = '0;
      last_rd = '0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hFEEDFACE;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("midrst late ld_valid", 32'(bus.ld_valid), 0);
         check("midrst late mem_valid", 32'(bus.mem_valid), 0);
      end
      bus.mem_ready = 1'b0;
      run_txn(tbl[0], "post-reset");

      // Random transactions against the reference model.
      for (int n = 0; n < 60; n++) begin
         rv.load  = 1'($urandom_range(0, 1));
         rv.size  = 2'($urandom_range(0, 3));
         rv.uns   = 1'($urandom_range(0, 1));
         rv.addr  = $urandom;
         rv.wdata = $urandom;
         rv.rd    = 5'($urandom_range(0, 31));
         rv.rdata = $urandom;
         rv.delay = $urandom_range(0, 3);
         run_txn(model(rv), $sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the 32-bit RISC-V core. It accepts one load or store per transaction from the execute stage and drives the data-memory bus with a valid/ready handshake. It generates byte enables and replicated store data, then aligns and sign- or zero-extends load data. Its load result feeds the memory-data input of the writeback select mux, and it stalls the pipeline while a transaction is in flight.

## Interface
Parameters:
- `XLEN`, 32: datapath and address width; only 32 is supported.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  EX stage presents a memory operation.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_load`  in  1  1 = load, 0 = store.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- `req_unsigned`  in  1  1 = zero-extend load (LBU/LHU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_rd`  in  5  load destination register.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus accept; for loads, `mem_rdata` is valid in the same cycle.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, bits [1:0] = 00.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read word.
- `ld_valid`  out  1  one-cycle pulse when the load result is ready.
- `ld_data`  out  32  extended load result, routed to the writeback mux.
- `ld_rd`  out  5  destination register of the load result.
- `stall`  out  1  high whenever state ≠ IDLE.
- `misalign`  out  1  one-cycle misaligned-access pulse; see Configuration.

## Operation
- FSM states: IDLE, BUS, RESP, and ERR (ERR exists only when `MISALIGN_TRAP_EN` is defined).
- IDLE:
  - `req_valid` accepts the request and registers addr, size, unsigned, rd, load and wdata.
  - Next state is BUS, or ERR if the request is misaligned and trapping is enabled.
- BUS:
  - `mem_valid` = 1 and all bus outputs are held stable until `mem_ready`.
  - On `mem_ready`, a load captures `mem_rdata` and goes to RESP; a store goes to IDLE.
- RESP: `ld_valid` = 1 for one cycle, then IDLE.
- ERR: `misalign` = 1 for one cycle, no bus access and no `ld_valid`, then IDLE.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extraction:
  - byte lane is chosen by addr[1:0]; half lane by addr[1].
  - The result is sign-extended unless `req_unsigned` is set; word loads ignore `req_unsigned`.
- Misaligned means: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
- `ld_data` and `ld_rd` hold their last value outside RESP.

## Timing
- Reset values: state IDLE; `req_ready` 1; `mem_valid`, `mem_we`, `ld_valid`, `misalign`, `stall` 0; `mem_addr`, `mem_be`, `mem_wdata`, `ld_data`, `ld_rd` 0.
- Cycle sequence:
  - Accept at edge N.
  - `mem_valid` is high from cycle N+1.
  - If `mem_ready` arrives in cycle N+k, `ld_valid` is high in cycle N+k+1.
  - Minimum load latency is 2 cycles; a store occupies k cycles.
- `req_ready` is low in BUS, RESP and ERR; `req_valid` is ignored there, and the request is not lost as long as EX holds it under `stall`.
- `mem_valid` never drops before `mem_ready` except on `rst`.
- Reset mid-transaction:
  - The next edge returns to IDLE and drops `mem_valid`.
  - The outstanding bus access is abandoned and no `ld_valid` is produced.
- `mem_ready` outside BUS is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned requests go to ERR and pulse `misalign` in cycle N+1.
  - No bus activity and no register writeback.
- Not defined:
  - The ERR state is absent and `misalign` is tied 0.
  - Misaligned halves use addr[1] only (addr[0] is ignored).
  - Misaligned words access the aligned word with `mem_be` = 1111.

## Test plan
- LW at 0x100, `mem_rdata` 0xDEADBEEF, `mem_ready` in the first BUS cycle → `mem_addr` 0x100, `mem_be` 1111, `ld_valid` 2 cycles after accept with `ld_data` 0xDEADBEEF and `ld_rd` echoed.
- LB and LBU at 0x103, `mem_rdata` 0x80112233 → LB `ld_data` 0xFFFFFF80, LBU 0x00000080.
- SH at 0x202, `req_wdata` 0x0000ABCD → `mem_addr` 0x200, `mem_be` 1100, `mem_wdata` 0xABCDABCD, `mem_we` 1, no `ld_valid`.
- LW with `mem_ready` delayed 3 cycles → `mem_valid` and `mem_addr` stable throughout, `stall` high, `req_ready` low, `ld_valid` one cycle after `mem_ready`.
- `rst` asserted in the second BUS cycle → next cycle IDLE, `mem_valid` 0, no `ld_valid` even if `mem_ready` then arrives.
- LW at 0x102 → with `MISALIGN_TRAP_EN`: `misalign` pulse in cycle N+1, `mem_valid` never 1; without it: `mem_addr` 0x100, normal load.
